// File: rtl/riscv_defines.sv
// Shared definitions for the tag-propagation execute slice.
//   ALU_MODE_WIDTH  : width of the tag-propagation mode field
//   tag_mode_e      : MODE_OLD / MODE_AND / MODE_OR / MODE_CLR
//   tag_ex_state_e  : IDLE / BUSY / DONE states of the tag execute FSM
//   tag_next()      : combinational next-tag function
package riscv_defines;

  localparam int ALU_MODE_WIDTH  = 2;
  localparam int TAINT_CNT_WIDTH = 16;

  typedef enum logic [ALU_MODE_WIDTH-1:0] {
    MODE_OLD = 2'b00,
    MODE_AND = 2'b01,
    MODE_OR  = 2'b10,
    MODE_CLR = 2'b11
  } tag_mode_e;

  typedef enum logic [1:0] {
    TAG_EX_IDLE = 2'b00,
    TAG_EX_BUSY = 2'b01,
    TAG_EX_DONE = 2'b10
  } tag_ex_state_e;

  // Single-operand instructions reuse rs1 in place of rs2, so AND/OR
  // collapse to a plain copy of rs1's tag.
  function automatic logic tag_next(
    input tag_mode_e mode,
    input logic      rs1_tag,
    input logic      rs2_tag,
    input logic      use_rs2,
    input logic      rd_old_tag
  );
    logic src2;
    src2 = use_rs2 ? rs2_tag : rs1_tag;
    case (mode)
      MODE_OLD: tag_next = rd_old_tag;
      MODE_AND: tag_next = rs1_tag & src2;
      MODE_OR:  tag_next = rs1_tag | src2;
      default:  tag_next = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_tag_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one (holds at all-ones)
//   clear      : restart the count; a simultaneous inc makes the result 1
//   count      : current count
module riscv_tag_sat_counter
  import riscv_defines::*;
#(
  parameter int WIDTH = TAINT_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // NOTE: sequential state is written with non-blocking assignments only so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/riscv_tag_prop_ex.sv
// Execute-stage tag propagation unit.
// Computes the destination-register tag in the issue cycle, waits for the
// multi-cycle datapath when needed, and holds the result until writeback
// takes it. Tainted handoffs are counted in a saturating counter.
//   issue_i / ready_o        : issue handshake from ID
//   mode_i, rs1/rs2_tag_i,
//   use_rs2_i, rd_old_tag_i  : operands of the next-tag function
//   multicycle_i, ex_done_i  : MUL/DIV in flight and its completion
//   wb_ready_i               : writeback accepts rd_tag_o
//   flush_i                  : discard everything, return to IDLE
//   cnt_clear_i              : clear the taint counter
//   tag_valid_o, rd_tag_o    : result toward writeback (state/register only)
//   busy_o                   : multi-cycle operation in flight
//   taint_cnt_o              : saturating count of tainted handoffs
module riscv_tag_prop_ex
  import riscv_defines::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_i,
  input  logic [ALU_MODE_WIDTH-1:0]  mode_i,
  input  logic                       rs1_tag_i,
  input  logic                       rs2_tag_i,
  input  logic                       use_rs2_i,
  input  logic                       rd_old_tag_i,
  input  logic                       multicycle_i,
  input  logic                       ex_done_i,
  input  logic                       wb_ready_i,
  input  logic                       flush_i,
  input  logic                       cnt_clear_i,
  output logic                       ready_o,
  output logic                       tag_valid_o,
  output logic                       rd_tag_o,
  output logic                       busy_o,
  output logic [TAINT_CNT_WIDTH-1:0] taint_cnt_o
);

  tag_ex_state_e state_q;
  logic          rd_tag_q;
  logic          accept;
  logic          handoff;
  logic          issue_tag;

  // A DONE result leaving this cycle frees the slot, so a new issue can be
  // taken in the same cycle without a bubble.
  assign ready_o = !flush_i &&
                   ((state_q == TAG_EX_IDLE) ||
                    ((state_q == TAG_EX_DONE) && wb_ready_i));
  assign accept  = issue_i && ready_o;
  assign handoff = (state_q == TAG_EX_DONE) && wb_ready_i && !flush_i;

  assign issue_tag = tag_next(tag_mode_e'(mode_i), rs1_tag_i, rs2_tag_i,
                              use_rs2_i, rd_old_tag_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TAG_EX_IDLE;
      rd_tag_q <= 1'b0;
    end else if (flush_i) begin
      state_q  <= TAG_EX_IDLE;
      rd_tag_q <= 1'b0;
    end else if (accept) begin
      // The tag is captured only here; operand changes afterwards are ignored.
      // ex_done_i in this cycle is irrelevant because the state is not BUSY.
      state_q  <= multicycle_i ? TAG_EX_BUSY : TAG_EX_DONE;
      rd_tag_q <= issue_tag;
    end else begin
      case (state_q)
        TAG_EX_BUSY: if (ex_done_i)  state_q <= TAG_EX_DONE;
        TAG_EX_DONE: if (wb_ready_i) state_q <= TAG_EX_IDLE;
        default:     state_q <= TAG_EX_IDLE;
      endcase
    end
  end

  // Decoded purely from state/register so no input reaches these outputs.
  assign tag_valid_o = (state_q == TAG_EX_DONE);
  assign busy_o      = (state_q == TAG_EX_BUSY);
  assign rd_tag_o    = rd_tag_q;

  riscv_tag_sat_counter #(
    .WIDTH (TAINT_CNT_WIDTH)
  ) u_taint_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handoff && rd_tag_q),
    .clear (cnt_clear_i),
    .count (taint_cnt_o)
  );

endmodule
